// File: rtl/vdp_text_blitter.sv
// Command-driven glyph/fill renderer feeding the VDP frame buffer, one pixel per clock.
// Optional feature: define VDP_TRANSP_BG_EN to add cmd_transp (skip background pixels).
module vdp_text_blitter #(
  parameter int PIX_W     = 24,
  parameter int VADR_W    = 16,
  parameter int FB_W_LOG2 = 8,
  parameter int CADR_W    = 11,
  parameter int GLYPH_H   = 8
) (
  input  logic                                             CLOCK_50,
  input  logic                                             RESET_N,
  input  logic                                             cmd_valid,
  output logic                                             cmd_ready,
  input  logic                                             cmd_op,
  input  logic [7:0]                                       cmd_char,
  input  logic [FB_W_LOG2-4:0]                             cmd_col,
  input  logic [VADR_W-FB_W_LOG2-$clog2(GLYPH_H)-1:0]      cmd_row,
  input  logic [PIX_W-1:0]                                 cmd_fg,
  input  logic [PIX_W-1:0]                                 cmd_bg,
`ifdef VDP_TRANSP_BG_EN
  input  logic                                             cmd_transp,
`endif
  output logic                                             done,
  output logic [CADR_W-1:0]                                crom_adr,
  input  logic [7:0]                                       crom_q,
  output logic [VADR_W-1:0]                                vram_wadr,
  output logic [PIX_W-1:0]                                 vram_d,
  output logic                                             vram_we
);

  localparam int GH_W  = $clog2(GLYPH_H);
  localparam int COL_W = FB_W_LOG2 - 3;
  localparam int ROW_W = VADR_W - FB_W_LOG2 - GH_W;
  localparam logic [GH_W-1:0] LAST_LINE = GH_W'(GLYPH_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DRAW, S_FILL, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         char_reg;
  logic [COL_W-1:0]   col_reg;
  logic [ROW_W-1:0]   row_reg;
  logic [PIX_W-1:0]   fg_reg, bg_reg;
  logic [GH_W-1:0]    line_reg;
  logic [2:0]         px_reg;
  logic [7:0]         shift_reg;
  logic [VADR_W-1:0]  fill_reg;
  logic               transp_reg;

  // State register plus the command/datapath registers that advance with it.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_reg <= S_IDLE;
      char_reg  <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
      fg_reg    <= '0;
      bg_reg    <= '0;
      line_reg  <= '0;
      px_reg    <= '0;
      shift_reg <= '0;
      fill_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            char_reg <= cmd_char;
            col_reg  <= cmd_col;
            row_reg  <= cmd_row;
            fg_reg   <= cmd_fg;
            bg_reg   <= cmd_bg;
            line_reg <= '0;
            px_reg   <= '0;
            fill_reg <= '0;
          end
        end
        S_LATCH: begin
          shift_reg <= crom_q;
          px_reg    <= '0;
        end
        S_DRAW: begin
          // Leftmost pixel sits in bit 7; shift it out one pixel per clock.
          shift_reg <= {shift_reg[6:0], 1'b0};
          px_reg    <= px_reg + 1'b1;
          if (px_reg == 3'd7) line_reg <= line_reg + 1'b1;
        end
        S_FILL: fill_reg <= fill_reg + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef VDP_TRANSP_BG_EN
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N)
      transp_reg <= 1'b0;
    else if (state_reg == S_IDLE && cmd_valid)
      transp_reg <= cmd_transp;
  end
`else
  assign transp_reg = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (cmd_valid) state_next = cmd_op ? S_FILL : S_FETCH;
      S_FETCH: state_next = S_LATCH;
      S_LATCH: state_next = S_DRAW;
      S_DRAW: begin
        if (px_reg == 3'd7)
          state_next = (line_reg == LAST_LINE) ? S_DONE : S_FETCH;
      end
      S_FILL:  if (fill_reg == '1) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    done      = 1'b0;
    vram_we   = 1'b0;
    vram_wadr = '0;
    vram_d    = '0;
    case (state_reg)
      S_IDLE: cmd_ready = 1'b1;
      S_DRAW: begin
        // Address is {cell row, glyph line, cell column, pixel}, so it never leaves the frame.
        vram_we   = shift_reg[7] || !transp_reg;
        vram_wadr = {row_reg, line_reg, col_reg, px_reg};
        vram_d    = shift_reg[7] ? fg_reg : bg_reg;
      end
      S_FILL: begin
        vram_we   = 1'b1;
        vram_wadr = fill_reg;
        vram_d    = bg_reg;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign crom_adr = {char_reg, line_reg};

endmodule

// File: tb/tb_vdp_text_blitter.sv
// Self-checking bench for vdp_text_blitter: randomized glyph commands checked cycle by
// cycle against an arithmetic model of the expected write schedule, plus fill and reset cases.
module tb_vdp_text_blitter;

`ifdef VDP_TRANSP_BG_EN
  localparam bit TR_EN = 1'b1;
`else
  localparam bit TR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        op;
    logic [7:0]  ch;
    logic [4:0]  col;
    logic [4:0]  row;
    logic [23:0] fg;
    logic [23:0] bg;
    logic        tr;
  } cmd_t;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [7:0]  cmd_char;
  logic [4:0]  cmd_col;
  logic [4:0]  cmd_row;
  logic [23:0] cmd_fg;
  logic [23:0] cmd_bg;
  logic        cmd_transp;
  logic        done;
  logic [10:0] crom_adr;
  logic [7:0]  crom_q;
  logic [15:0] vram_wadr;
  logic [23:0] vram_d;
  logic        vram_we;

  logic [7:0]  crom_mem [0:2047];
  int          tests = 0;
  int          failed = 0;
  logic [15:0] last_wadr;

  vdp_text_blitter dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_char  (cmd_char),
    .cmd_col   (cmd_col),
    .cmd_row   (cmd_row),
    .cmd_fg    (cmd_fg),
    .cmd_bg    (cmd_bg),
`ifdef VDP_TRANSP_BG_EN
    .cmd_transp(cmd_transp),
`endif
    .done      (done),
    .crom_adr  (crom_adr),
    .crom_q    (crom_q),
    .vram_wadr (vram_wadr),
    .vram_d    (vram_d),
    .vram_we   (vram_we)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Character ROM with a registered read port.
  always @(posedge CLOCK_50) crom_q <= crom_mem[crom_adr];

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op  = 1'b0;
    c.ch  = 8'($urandom);
    c.col = 5'($urandom);
    c.row = 5'($urandom);
    c.fg  = 24'($urandom);
    c.bg  = 24'($urandom);
    c.tr  = 1'($urandom);
    return c;
  endfunction

  task automatic drive(input cmd_t c, input logic v);
    cmd_valid  = v;
    cmd_op     = c.op;
    cmd_char   = c.ch;
    cmd_col    = c.col;
    cmd_row    = c.row;
    cmd_fg     = c.fg;
    cmd_bg     = c.bg;
    cmd_transp = c.tr;
  endtask

  // Runs one glyph command and checks every cycle from acceptance to the IDLE that follows.
  // issue=0 means the command is already presented and will be taken at the next edge.
  task automatic glyph_scenario(input bit issue, input cmd_t c, input bit nxt_v,
                                input cmd_t nxt, input string name, output int nwrites);
    int          writes, exp_writes, r, p, a;
    bit          tr;
    logic [7:0]  rowbits;
    logic        exp_we;
    logic [23:0] exp_d;
    logic [10:0] exp_cadr;
    tr = TR_EN && c.tr;
    writes = 0;
    exp_writes = 0;
    if (issue) begin
      @(negedge CLOCK_50);
      tests++;
      if (cmd_ready !== 1'b1) begin
        failed++;
        $display("FAIL %s ready_at_issue got %b want 1", name, cmd_ready);
      end
      drive(c, 1'b1);
    end
    @(posedge CLOCK_50);
    #1 drive(nxt, nxt_v);
    for (int k = 1; k <= 82; k++) begin
      @(negedge CLOCK_50);
      if (vram_we === 1'b1) begin
        writes++;
        last_wadr = vram_wadr;
      end
      if (k <= 80) begin
        r = (k - 1) / 10;
        p = (k - 1) % 10 - 2;
        rowbits = crom_mem[{c.ch, r[2:0]}];
        exp_we = 1'b0;
        if (p >= 0) exp_we = rowbits[7-p] || !tr;
        tests++;
        if (vram_we !== exp_we) begin
          failed++;
          $display("FAIL %s we k=%0d got %b want %b", name, k, vram_we, exp_we);
        end
        if (exp_we) begin
          exp_writes++;
          a = ((int'(c.row) * 8 + r) * 256) + int'(c.col) * 8 + p;
          exp_d = rowbits[7-p] ? c.fg : c.bg;
          tests++;
          if (vram_wadr !== a[15:0]) begin
            failed++;
            $display("FAIL %s wadr k=%0d got %h want %h", name, k, vram_wadr, a[15:0]);
          end
          tests++;
          if (vram_d !== exp_d) begin
            failed++;
            $display("FAIL %s data k=%0d got %h want %h", name, k, vram_d, exp_d);
          end
        end
        if (p == -2) begin
          exp_cadr = {c.ch, r[2:0]};
          tests++;
          if (crom_adr !== exp_cadr) begin
            failed++;
            $display("FAIL %s crom_adr k=%0d got %h want %h", name, k, crom_adr, exp_cadr);
          end
        end
        tests++;
        if (done !== 1'b0 || cmd_ready !== 1'b0) begin
          failed++;
          $display("FAIL %s busy_flags k=%0d got done=%b ready=%b want 0/0", name, k, done, cmd_ready);
        end
      end else if (k == 81) begin
        tests++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || vram_we !== 1'b0) begin
          failed++;
          $display("FAIL %s done_cycle got done=%b ready=%b we=%b want 1/0/0", name, done, cmd_ready, vram_we);
        end
      end else begin
        tests++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || vram_we !== 1'b0) begin
          failed++;
          $display("FAIL %s idle_after got done=%b ready=%b we=%b want 0/1/0", name, done, cmd_ready, vram_we);
        end
      end
    end
    tests++;
    if (writes != exp_writes) begin
      failed++;
      $display("FAIL %s write_count got %0d want %0d", name, writes, exp_writes);
    end
    nwrites = writes;
    $display("[TB] glyph %s ch=%02h col=%0d row=%0d tr=%0d writes=%0d", name, c.ch, c.col, c.row, tr, writes);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    drive(rand_cmd(), 1'b0);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    tests++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || vram_we !== 1'b0) begin
      failed++;
      $display("FAIL reset_flags got ready=%b done=%b we=%b want 1/0/0", cmd_ready, done, vram_we);
    end
    tests++;
    if (crom_adr !== 11'd0 || vram_wadr !== 16'd0 || vram_d !== 24'd0) begin
      failed++;
      $display("FAIL reset_buses got crom=%h wadr=%h d=%h want 0/0/0", crom_adr, vram_wadr, vram_d);
    end
    RESET_N = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_example();
    cmd_t c;
    int n;
    c = '0;
    c.ch = 8'h41; c.col = 5'd2; c.row = 5'd1; c.fg = 24'hFFFFFF; c.bg = 24'h000000;
    crom_mem[{8'h41, 3'd0}] = 8'h81;
    glyph_scenario(1'b1, c, 1'b0, rand_cmd(), "example", n);
    tests++;
    if (n != 64) begin
      failed++;
      $display("FAIL example_total got %0d want 64", n);
    end
  endtask

  task automatic test_random_glyphs();
    int n;
    for (int i = 0; i < 12; i++)
      glyph_scenario(1'b1, rand_cmd(), 1'b0, rand_cmd(), "random", n);
  endtask

  task automatic test_back_to_back();
    cmd_t a, b;
    int n;
    a = rand_cmd();
    b = rand_cmd();
    glyph_scenario(1'b1, a, 1'b1, b, "b2b_first", n);
    glyph_scenario(1'b0, b, 1'b0, rand_cmd(), "b2b_second", n);
  endtask

  task automatic test_max_corner();
    cmd_t c;
    int n;
    c = rand_cmd();
    c.col = 5'd31; c.row = 5'd31; c.tr = 1'b0;
    for (int r = 0; r < 8; r++) crom_mem[{c.ch, 3'(r)}] = 8'hFF;
    glyph_scenario(1'b1, c, 1'b0, rand_cmd(), "max_corner", n);
    tests++;
    if (last_wadr !== 16'hFFFF) begin
      failed++;
      $display("FAIL max_corner_last got %h want ffff", last_wadr);
    end
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    c = rand_cmd();
    c.tr = 1'b0;
    @(negedge CLOCK_50);
    drive(c, 1'b1);
    @(posedge CLOCK_50);
    #1 drive(rand_cmd(), 1'b0);
    repeat (37) @(negedge CLOCK_50);
    tests++;
    if (vram_we !== 1'b1) begin
      failed++;
      $display("FAIL midreset_pre_we got %b want 1", vram_we);
    end
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    tests++;
    if (vram_we !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      failed++;
      $display("FAIL midreset_after got we=%b ready=%b done=%b want 0/1/0", vram_we, cmd_ready, done);
    end
    RESET_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLOCK_50);
      tests++;
      if (done !== 1'b0 || vram_we !== 1'b0 || cmd_ready !== 1'b1) begin
        failed++;
        $display("FAIL midreset_idle k=%0d got done=%b we=%b ready=%b want 0/0/1", k, done, vram_we, cmd_ready);
      end
    end
    $display("[TB] mid-command reset checked");
  endtask

  task automatic test_fill();
    cmd_t c;
    int writes, adr_err, d_err, done_k;
    logic [15:0] first_a, last_a;
    c = rand_cmd();
    c.op = 1'b1;
    c.bg = 24'h123456;
    writes = 0; adr_err = 0; d_err = 0; done_k = 0;
    first_a = 16'hxxxx; last_a = 16'hxxxx;
    @(negedge CLOCK_50);
    tests++;
    if (cmd_ready !== 1'b1) begin
      failed++;
      $display("FAIL fill_ready_at_issue got %b want 1", cmd_ready);
    end
    drive(c, 1'b1);
    @(posedge CLOCK_50);
    #1 drive(rand_cmd(), 1'b0);
    for (int k = 1; k <= 70000; k++) begin
      @(negedge CLOCK_50);
      if (vram_we === 1'b1) begin
        if (writes == 0) first_a = vram_wadr;
        if (vram_wadr !== writes[15:0]) adr_err++;
        if (vram_d !== 24'h123456) d_err++;
        last_a = vram_wadr;
        writes++;
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    tests++;
    if (writes != 65536) begin failed++; $display("FAIL fill_count got %0d want 65536", writes); end
    tests++;
    if (first_a !== 16'h0000) begin failed++; $display("FAIL fill_first got %h want 0000", first_a); end
    tests++;
    if (last_a !== 16'hFFFF) begin failed++; $display("FAIL fill_last got %h want ffff", last_a); end
    tests++;
    if (adr_err != 0) begin failed++; $display("FAIL fill_order got %0d bad addresses want 0", adr_err); end
    tests++;
    if (d_err != 0) begin failed++; $display("FAIL fill_data got %0d bad pixels want 0", d_err); end
    tests++;
    if (done_k != 65537) begin failed++; $display("FAIL fill_done_cycle got %0d want 65537", done_k); end
    @(negedge CLOCK_50);
    tests++;
    if (cmd_ready !== 1'b1 || vram_we !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL fill_idle got ready=%b we=%b done=%b want 1/0/0", cmd_ready, vram_we, done);
    end
    $display("[TB] fill bg=123456 writes=%0d done_at=%0d", writes, done_k);
  endtask

`ifdef VDP_TRANSP_BG_EN
  task automatic test_transp();
    cmd_t c;
    int n;
    c = rand_cmd();
    c.tr = 1'b1;
    for (int r = 0; r < 8; r++) crom_mem[{c.ch, 3'(r)}] = 8'hAA;
    glyph_scenario(1'b1, c, 1'b0, rand_cmd(), "transp", n);
    tests++;
    if (n != 32) begin
      failed++;
      $display("FAIL transp_total got %0d want 32", n);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) crom_mem[i] = 8'($urandom);
    last_wadr = '0;
    test_reset();
    test_example();
    test_random_glyphs();
    test_back_to_back();
    test_max_corner();
    test_reset_mid();
`ifdef VDP_TRANSP_BG_EN
    test_transp();
`endif
    test_fill();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
